// File: rtl/affine_sched_ctrl.sv
// Affine schedule controller: asserts valid on cycles whose count matches
// start + sum(idx_i*stride_i) for a runtime-configured loop nest.
module affine_sched_ctrl #(
    parameter int NUM_DIMS = 6,
    parameter int WIDTH    = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clk_en,
    input  logic             flush,
    input  logic             cfg_we,
    input  logic [3:0]       cfg_addr,
    input  logic [WIDTH-1:0] cfg_wdata,
    input  logic             start,
    output logic             valid,
    output logic [WIDTH-1:0] sched_time,
    output logic             busy,
    output logic             done,
    output logic             sched_err
);
    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

    state_t state, state_nx;

    logic [WIDTH-1:0] dims_cfg;
    logic [WIDTH-1:0] start_cfg;
    logic [WIDTH-1:0] range_cfg  [NUM_DIMS];
    logic [WIDTH-1:0] stride_cfg [NUM_DIMS];

    logic [WIDTH-1:0] cycle_time;
    logic [WIDTH-1:0] idx    [NUM_DIMS];
    logic [WIDTH-1:0] idx_nx [NUM_DIMS];
    logic [WIDTH-1:0] off    [NUM_DIMS];
    logic [WIDTH-1:0] off_nx [NUM_DIMS];
    logic [WIDTH-1:0] sched_nx;
    logic [NUM_DIMS-1:0] active;
    logic last_iter;
    logic late;
    logic accept;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dims_cfg  <= '0;
            start_cfg <= '0;
            for (int i = 0; i < NUM_DIMS; i++) begin
                range_cfg[i]  <= '0;
                stride_cfg[i] <= '0;
            end
        end else if (cfg_we && state != RUN) begin
            if (cfg_addr == 4'd0) dims_cfg <= cfg_wdata;
            if (cfg_addr == 4'd1) start_cfg <= cfg_wdata;
            for (int i = 0; i < NUM_DIMS; i++) begin
                if (cfg_addr == 4'(i + 2)) range_cfg[i] <= cfg_wdata;
                if (cfg_addr == 4'(i + 8)) stride_cfg[i] <= cfg_wdata;
            end
        end
    end

    // off_i tracks idx_i*stride_i so the schedule time needs only adders
    always_comb begin
        logic             c;
        logic [WIDTH-1:0] rng_m1;
        logic [WIDTH-1:0] sum;
        c   = 1'b1;
        sum = start_cfg;
        for (int i = 0; i < NUM_DIMS; i++) begin
            active[i] = dims_cfg > WIDTH'(i);
            rng_m1    = (range_cfg[i] == '0) ? '0 : range_cfg[i] - ONE;
            idx_nx[i] = idx[i];
            off_nx[i] = off[i];
            if (active[i] && c) begin
                if (idx[i] == rng_m1) begin
                    idx_nx[i] = '0;
                    off_nx[i] = '0;
                end else begin
                    idx_nx[i] = idx[i] + ONE;
                    off_nx[i] = off[i] + stride_cfg[i];
                    c         = 1'b0;
                end
            end
            sum = sum + off_nx[i];
        end
        last_iter = c;
        sched_nx  = sum;
    end

    assign valid  = (state == RUN) && clk_en && (cycle_time == sched_time);
    assign late   = (state == RUN) && clk_en && (sched_time < cycle_time);
    assign accept = (state == IDLE) && start && clk_en && !flush;
    assign busy   = (state == RUN);
    assign done   = (state == DONE) && clk_en;

    always_comb begin
        state_nx = state;
        unique case (state)
            IDLE: begin
                if (accept) state_nx = active[0] ? RUN : DONE;
            end
            RUN: begin
                if (late || (valid && last_iter)) state_nx = DONE;
            end
            DONE: begin
                if (clk_en) state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
        if (flush) state_nx = IDLE;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            cycle_time <= '0;
            sched_time <= '0;
            sched_err  <= 1'b0;
            for (int i = 0; i < NUM_DIMS; i++) begin
                idx[i] <= '0;
                off[i] <= '0;
            end
        end else begin
            state <= state_nx;
            if (flush) begin
                cycle_time <= '0;
                sched_time <= '0;
                for (int i = 0; i < NUM_DIMS; i++) begin
                    idx[i] <= '0;
                    off[i] <= '0;
                end
            end else if (accept) begin
                cycle_time <= '0;
                sched_time <= start_cfg;
                sched_err  <= 1'b0;
                for (int i = 0; i < NUM_DIMS; i++) begin
                    idx[i] <= '0;
                    off[i] <= '0;
                end
            end else if (state == RUN && clk_en) begin
                if (cycle_time != '1) cycle_time <= cycle_time + ONE;
                if (late) begin
                    sched_err <= 1'b1;
                end else if (valid) begin
                    sched_time <= sched_nx;
                    for (int i = 0; i < NUM_DIMS; i++) begin
                        idx[i] <= idx_nx[i];
                        off[i] <= off_nx[i];
                    end
                end
            end
        end
    end
endmodule

// File: tb/tb_affine_sched_ctrl.sv
// Directed bench for affine_sched_ctrl: schedule sequences, stall,
// late detection, flush, config edge cases and async reset.
module tb_affine_sched_ctrl;
    localparam int W = 16;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         clk_en = 1'b0;
    logic         flush = 1'b0;
    logic         cfg_we = 1'b0;
    logic [3:0]   cfg_addr = '0;
    logic [W-1:0] cfg_wdata = '0;
    logic         start = 1'b0;
    logic         valid;
    logic [W-1:0] sched_time;
    logic         busy;
    logic         done;
    logic         sched_err;

    int n_tests = 0;
    int n_fail = 0;
    int vt[$];
    int vw[$];
    int done_cnt;
    int done_w;
    bit err_seen;
    bit busy_bad;

    affine_sched_ctrl #(.NUM_DIMS(6), .WIDTH(W)) dut (
        .clk(clk),
        .rst_n(rst_n),
        .clk_en(clk_en),
        .flush(flush),
        .cfg_we(cfg_we),
        .cfg_addr(cfg_addr),
        .cfg_wdata(cfg_wdata),
        .start(start),
        .valid(valid),
        .sched_time(sched_time),
        .busy(busy),
        .done(done),
        .sched_err(sched_err)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic cfg_write(input logic [3:0] a, input logic [W-1:0] d);
        @(negedge clk);
        cfg_we = 1'b1;
        cfg_addr = a;
        cfg_wdata = d;
        @(negedge clk);
        cfg_we = 1'b0;
    endtask

    task automatic cfg_basic();
        cfg_write(4'd0, 16'd2);
        cfg_write(4'd1, 16'd10);
        cfg_write(4'd2, 16'd2);
        cfg_write(4'd3, 16'd3);
        cfg_write(4'd8, 16'd1);
        cfg_write(4'd9, 16'd4);
    endtask

    // bench ct mirrors the DUT cycle counter: 0 in the first RUN cycle
    task automatic run_sched(input int stall_at, input int flush_at,
                             input bit lock_wr, input int budget);
        int ct;
        int st_left;
        bit stalled;
        vt.delete();
        vw.delete();
        done_cnt = 0;
        done_w = -1;
        err_seen = 1'b0;
        busy_bad = 1'b0;
        ct = 0;
        st_left = 0;
        stalled = 1'b0;
        @(negedge clk);
        start = 1'b1;
        clk_en = 1'b1;
        flush = 1'b0;
        for (int w = 0; w < budget; w++) begin
            @(negedge clk);
            start = 1'b0;
            flush = 1'b0;
            clk_en = 1'b1;
            cfg_we = lock_wr && (w == 3);
            cfg_addr = 4'd2;
            cfg_wdata = 16'd5;
            if (ct == stall_at && !stalled) begin
                st_left = 3;
                stalled = 1'b1;
            end
            if (st_left > 0) begin
                clk_en = 1'b0;
                st_left--;
            end
            if (ct == flush_at) begin
                flush = 1'b1;
                start = 1'b1;
            end
            #1;
            if (valid && !flush) begin
                vt.push_back(ct);
                vw.push_back(w);
            end
            if (done) begin
                done_cnt++;
                done_w = w;
                if (busy) busy_bad = 1'b1;
            end
            if (sched_err) err_seen = 1'b1;
            if (clk_en) ct++;
        end
        cfg_we = 1'b0;
        flush = 1'b0;
        start = 1'b0;
        clk_en = 1'b1;
    endtask

    task automatic expect_seq(input string tag, input int exp[$]);
        check({tag, ".n"}, vt.size(), exp.size());
        for (int i = 0; i < exp.size() && i < vt.size(); i++)
            check($sformatf("%s.v%0d", tag, i), vt[i], exp[i]);
    endtask

    initial begin
        int e[$];
        #12;
        check("rst.valid", valid, 0);
        check("rst.busy", busy, 0);
        check("rst.done", done, 0);
        check("rst.err", sched_err, 0);
        check("rst.time", sched_time, 0);
        @(negedge clk);
        rst_n = 1'b1;
        clk_en = 1'b1;

        cfg_basic();
        run_sched(-1, -1, 1'b1, 30);
        e = '{10, 11, 14, 15, 18, 19};
        expect_seq("basic", e);
        check("basic.done_cnt", done_cnt, 1);
        check("basic.done_w", done_w, 20);
        check("basic.busy_at_done", busy_bad, 0);
        check("basic.err", err_seen, 0);

        run_sched(12, -1, 1'b0, 33);
        expect_seq("stall", e);
        if (vw.size() > 2) begin
            check("stall.w10", vw[0], 10);
            check("stall.w14", vw[2], 17);
        end else begin
            check("stall.vw_size", vw.size(), 6);
        end
        check("stall.done_w", done_w, 23);

        run_sched(-1, 15, 1'b0, 20);
        e = '{10, 11, 14};
        expect_seq("flush", e);
        check("flush.no_done", done_cnt, 0);
        check("flush.busy", busy, 0);
        run_sched(-1, -1, 1'b0, 30);
        e = '{10, 11, 14, 15, 18, 19};
        expect_seq("replay", e);
        check("replay.done_w", done_w, 20);

        cfg_write(4'd0, 16'd1);
        cfg_write(4'd1, 16'd5);
        cfg_write(4'd2, 16'd3);
        cfg_write(4'd8, 16'd0);
        run_sched(-1, -1, 1'b0, 15);
        e = '{5};
        expect_seq("late", e);
        check("late.err", err_seen, 1);
        check("late.done_cnt", done_cnt, 1);
        check("late.done_w", done_w, 7);
        check("late.sticky", sched_err, 1);

        cfg_write(4'd0, 16'd0);
        run_sched(-1, -1, 1'b0, 5);
        check("dims0.nvalid", vt.size(), 0);
        check("dims0.done_w", done_w, 0);
        check("dims0.err_clr", sched_err, 0);

        cfg_write(4'd0, 16'd7);
        cfg_write(4'd1, 16'd2);
        cfg_write(4'd2, 16'd0);
        cfg_write(4'd8, 16'd1);
        for (int i = 1; i < 5; i++) begin
            cfg_write(4'(i + 2), 16'd1);
            cfg_write(4'(i + 8), 16'd0);
        end
        cfg_write(4'd7, 16'd2);
        cfg_write(4'd13, 16'd3);
        run_sched(-1, -1, 1'b0, 12);
        e = '{2, 5};
        expect_seq("dims7", e);
        check("dims7.done_w", done_w, 6);

        cfg_basic();
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (11) @(negedge clk);
        #1;
        check("arst.pre_valid", valid, 1);
        check("arst.pre_time", sched_time, 11);
        #1;
        rst_n = 1'b0;
        #1;
        check("arst.valid", valid, 0);
        check("arst.busy", busy, 0);
        check("arst.time", sched_time, 0);
        check("arst.done", done, 0);
        @(negedge clk);
        rst_n = 1'b1;
        run_sched(-1, -1, 1'b0, 5);
        check("arst.cfg_nvalid", vt.size(), 0);
        check("arst.cfg_done_w", done_w, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
